// File: rtl/ifu_fetch_pkg.sv
// Shared constants and FSM encoding for the instruction fetch stage.
package ifu_fetch_pkg;

  localparam int PC_W   = 64;
  localparam int INST_W = 32;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifu_pc_gen.sv
// Architectural fetch PC register with next-PC selection:
// redirect (word-aligned) > +4 after an accepted response > hold.
module ifu_pc_gen #(
  parameter int                 PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect_valid_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  input  logic                advance_i,
  output logic [PC_WIDTH-1:0] pc_o
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i) begin
      pc_d = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
    end else if (advance_i) begin
      pc_d = pc_q + PC_WIDTH'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// Fetch stage: single-outstanding imem requests, one-entry output buffer,
// redirects that drop any response belonging to a stale fetch.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int                  PC_WIDTH   = PC_W,
  parameter int                  INST_WIDTH = INST_W,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  input  logic                  id_ready,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_WIDTH-1:0]   imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_data,
  output logic                  if_valid,
  output logic [PC_WIDTH-1:0]   if_pc,
  output logic [INST_WIDTH-1:0] if_inst,
  output logic [1:0]            dbg_state_o
);

  // Handshakes: a request transfers in any cycle where imem_req_valid && imem_req_ready;
  // a buffered entry transfers in any cycle where if_valid && id_ready; memory
  // returns exactly one imem_resp_valid pulse per transferred request.

  localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(NOP_INST);

  fetch_state_e            state_q, state_d;
  logic                    buf_valid_q, buf_valid_d;
  logic [PC_WIDTH-1:0]     buf_pc_q, buf_pc_d;
  logic [INST_WIDTH-1:0]   buf_inst_q, buf_inst_d;
  logic [PC_WIDTH-1:0]     pc_q;
  logic                    resp_load;

  // Issuing only when the buffer will be free guarantees a response never
  // lands on an unconsumed entry.
  assign imem_req_valid = !rst && (state_q == S_REQ) && !redirect_valid &&
                          (!buf_valid_q || id_ready);
  assign resp_load      = (state_q == S_WAIT) && imem_resp_valid && !redirect_valid;

  ifu_pc_gen #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .advance_i        (resp_load),
    .pc_o             (pc_q)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ: begin
        if (imem_req_valid && imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid)     state_d = S_REQ;
        else if (redirect_valid) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (imem_resp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_pc_d    = buf_pc_q;
    buf_inst_d  = buf_inst_q;
    if (redirect_valid) begin
      buf_valid_d = 1'b0;
    end else if (resp_load) begin
      buf_valid_d = 1'b1;
      buf_pc_d    = pc_q;
      buf_inst_d  = imem_resp_data;
    end else if (id_ready && buf_valid_q) begin
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_REQ;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= '0;
      buf_inst_q  <= NOP;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_inst_q  <= buf_inst_d;
    end
  end

  assign imem_req_addr = pc_q;
  assign if_valid      = buf_valid_q;
  assign if_pc         = buf_pc_q;
  assign if_inst       = buf_valid_q ? buf_inst_q : NOP;
  assign dbg_state_o   = state_q;

endmodule
